// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with the architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both take one bit per cycle
// over DATA_W cycles. Signed operations work on magnitudes and fix the signs at completion.
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    logic [0:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        op_q;
    logic              neg_a_q;   // rs was negative (signed ops only)
    logic              neg_b_q;   // rt was negative (signed ops only)
    // acc_q: running partial-product high half, or partial remainder.
    // lsb_q: multiplier shifting out / product low half, or dividend shifting out / quotient.
    // opb_q: multiplicand or divisor magnitude.
    logic [DATA_W-1:0] acc_q, lsb_q, opb_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic              done_q;

    // Operand capture: signed ops strip the sign so the datapath only sees magnitudes.
    logic              cap_signed, cap_neg_a, cap_neg_b;
    logic [DATA_W-1:0] cap_mag_a, cap_mag_b;
    always_comb begin
        cap_signed = ~op_i[0];
        cap_neg_a  = cap_signed & rs_data_i[DATA_W-1];
        cap_neg_b  = cap_signed & rt_data_i[DATA_W-1];
        cap_mag_a  = cap_neg_a ? -rs_data_i : rs_data_i;
        cap_mag_b  = cap_neg_b ? -rt_data_i : rt_data_i;
    end

    // One iteration of either algorithm, plus the sign-corrected final result.
    logic [DATA_W:0]     mul_sum, div_sh, div_diff;
    logic                div_ok;
    logic [DATA_W-1:0]   nxt_acc, nxt_lsb, res_hi, res_lo;
    logic [2*DATA_W-1:0] prod_fix;
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lsb_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = {acc_q, lsb_q[DATA_W-1]};
        div_diff = div_sh - {1'b0, opb_q};
        div_ok   = ~div_diff[DATA_W];
        if (op_q[1]) begin
            nxt_acc = div_ok ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0];
            nxt_lsb = {lsb_q[DATA_W-2:0], div_ok};
        end else begin
            nxt_acc = mul_sum[DATA_W:1];
            nxt_lsb = {mul_sum[0], lsb_q[DATA_W-1:1]};
        end
        prod_fix = (neg_a_q ^ neg_b_q) ? -{nxt_acc, nxt_lsb} : {nxt_acc, nxt_lsb};
        if (op_q[1]) begin
            // A zero divisor yields an all-ones quotient. The remainder holds the dividend
            // magnitude, and the dividend sign fix restores the raw rs value.
            res_lo = (opb_q == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -nxt_lsb : nxt_lsb);
            res_hi = neg_a_q ? -nxt_acc : nxt_acc;
        end else begin
            res_hi = prod_fix[2*DATA_W-1:DATA_W];
            res_lo = prod_fix[DATA_W-1:0];
        end
    end

    // Control FSM, datapath registers and HI/LO update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            acc_q   <= '0;
            lsb_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else if (state_q == S_IDLE) begin
            done_q <= 1'b0;
            if (start_i) begin
                state_q <= S_CALC;
                cnt_q   <= '0;
                op_q    <= op_i;
                neg_a_q <= cap_neg_a;
                neg_b_q <= cap_neg_b;
                acc_q   <= '0;
                lsb_q   <= cap_mag_a;
                opb_q   <= cap_mag_b;
            end else begin
                if (hi_we_i) hi_q <= wdata_i;
                if (lo_we_i) lo_q <= wdata_i;
            end
        end else begin
            acc_q <= nxt_acc;
            lsb_q <= nxt_lsb;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
                hi_q    <= res_hi;
                lo_q    <= res_lo;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
            end
        end
    end

    assign busy_o = (state_q == S_CALC);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
